vx_socket_gbar_agg: RTL and testbench

Socket-level global-barrier aggregator. It sits between the NUM_CORES per-core barrier ports of a socket and the single cluster-level barrier port. Unlike a plain arbiter, it coalesces the arrivals of the local cores for each barrier ID and sends exactly one upstream request per socket per barrier round. It then broadcasts the upstream release to all local cores.

---
 rtl/vx_socket_gbar_agg.sv | 189 ++++++++++++++++++
 tb/tb_vx_socket_gbar_agg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_socket_gbar_agg.sv
// Socket-level global-barrier aggregator: coalesces per-core arrivals for each barrier ID
// into one cluster request per round, then broadcasts the cluster release to all cores.
module vx_socket_gbar_agg #(
    parameter int SOCKET_ID    = 0,
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int SIZE_W       = 8,
    localparam int BAR_W       = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_req_valid,
    input  logic [NUM_CORES*BAR_W-1:0]    core_req_id,
    input  logic [NUM_CORES*SIZE_W-1:0]   core_req_size_m1,
    output logic [NUM_CORES-1:0]          core_req_ready,
    output logic                          core_rsp_valid,
    output logic [BAR_W-1:0]              core_rsp_id,
    output logic                          up_req_valid,
    output logic [BAR_W-1:0]              up_req_id,
    output logic [SIZE_W-1:0]             up_req_size_m1,
    input  logic                          up_req_ready,
    input  logic                          up_rsp_valid,
    input  logic [BAR_W-1:0]              up_rsp_id,
    output logic                          busy
);
    localparam int CNT_W  = $clog2(NUM_CORES + 1);
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LOG_NC = $clog2(NUM_CORES);
    localparam int E_W    = SIZE_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SEND, WAIT} bar_state_e;

    bar_state_e           state_q  [NUM_BARRIERS];
    bar_state_e           state_n  [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_q   [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_n   [NUM_BARRIERS];
    logic [CNT_W-1:0]     count_q  [NUM_BARRIERS];
    logic [CNT_W-1:0]     count_n  [NUM_BARRIERS];
    logic [E_W-1:0]       expect_q [NUM_BARRIERS];
    logic [E_W-1:0]       expect_n [NUM_BARRIERS];
    logic [SIZE_W-1:0]    size_q   [NUM_BARRIERS];
    logic [SIZE_W-1:0]    size_n   [NUM_BARRIERS];

    logic [CORE_W-1:0]    rr_ptr;
    logic [NUM_CORES-1:0] eligible;
    logic [BAR_W-1:0]     req_id;
    logic                 win_found;
    logic [CORE_W-1:0]    win_idx;
    int                   cand;
    logic [BAR_W-1:0]     win_id;
    logic [SIZE_W-1:0]    win_size;
    int                   rem;
    logic [E_W-1:0]       first_e;
    logic                 up_fire;
    logic                 rsp_hit;
    logic                 sel_found;
    logic [BAR_W-1:0]     sel_id;
    logic [SIZE_W-1:0]    sel_size;
    logic                 any_active;

    // A core may join a round only once, and never while the round is upstream.
    always_comb begin
        eligible = '0;
        req_id   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            req_id      = core_req_id[i*BAR_W +: BAR_W];
            eligible[i] = core_req_valid[i] && !mask_q[req_id][i]
                          && (state_q[req_id] == IDLE || state_q[req_id] == COLLECT);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_CORES;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = CORE_W'(cand);
            end
        end
        if (reset) win_found = 1'b0;
    end

    assign core_req_ready = win_found ? (NUM_CORES'(1) << win_idx) : '0;
    assign win_id         = core_req_id[int'(win_idx)*BAR_W +: BAR_W];
    assign win_size       = core_req_size_m1[int'(win_idx)*SIZE_W +: SIZE_W];
    assign up_fire        = up_req_valid && up_req_ready;
    assign rsp_hit        = up_rsp_valid && (state_q[up_rsp_id] == WAIT);

    // Local share of the global participant count, clamped to the cores present here.
    always_comb begin
        rem = int'(win_size) + 1 - SOCKET_ID * NUM_CORES;
        if (rem > NUM_CORES)  first_e = E_W'(NUM_CORES);
        else if (rem < 1)     first_e = E_W'(1);
        else                  first_e = E_W'(rem);
    end

    always_comb begin
        state_n  = state_q;
        mask_n   = mask_q;
        count_n  = count_q;
        expect_n = expect_q;
        size_n   = size_q;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (state_q[b] == SEND && up_fire && up_req_id == BAR_W'(b))
                state_n[b] = WAIT;
            if (state_q[b] == WAIT && up_rsp_valid && up_rsp_id == BAR_W'(b)) begin
                state_n[b] = IDLE;
                mask_n[b]  = '0;
                count_n[b] = '0;
            end
        end
        if (win_found) begin
            if (state_q[win_id] == IDLE) begin
                mask_n[win_id]   = core_req_ready;
                count_n[win_id]  = CNT_W'(1);
                expect_n[win_id] = first_e;
                size_n[win_id]   = win_size;
                state_n[win_id]  = (first_e == E_W'(1)) ? SEND : COLLECT;
            end else begin
                mask_n[win_id]  = mask_q[win_id] | core_req_ready;
                count_n[win_id] = count_q[win_id] + CNT_W'(1);
                if (E_W'(count_q[win_id]) + E_W'(1) == expect_q[win_id])
                    state_n[win_id] = SEND;
            end
        end
    end

    // Lowest ID wins among entries that will be in SEND after this edge.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
            if (state_n[b] == SEND) begin
                sel_found = 1'b1;
                sel_id    = BAR_W'(b);
            end
        end
    end

    assign sel_size = size_n[sel_id] >> LOG_NC;

    always_comb begin
        any_active = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++)
            if (state_q[b] != IDLE) any_active = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b]  <= IDLE;
                mask_q[b]   <= '0;
                count_q[b]  <= '0;
                expect_q[b] <= '0;
                size_q[b]   <= '0;
            end
            rr_ptr         <= '0;
            up_req_valid   <= 1'b0;
            up_req_id      <= '0;
            up_req_size_m1 <= '0;
            core_rsp_valid <= 1'b0;
            core_rsp_id    <= '0;
            busy           <= 1'b0;
        end else begin
            state_q  <= state_n;
            mask_q   <= mask_n;
            count_q  <= count_n;
            expect_q <= expect_n;
            size_q   <= size_n;
            if (win_found)
                rr_ptr <= (win_idx == CORE_W'(NUM_CORES - 1)) ? '0 : win_idx + CORE_W'(1);
            // Held request is never replaced until the cluster accepts it.
            if (!up_req_valid || up_req_ready) begin
                up_req_valid   <= sel_found;
                up_req_id      <= sel_id;
                up_req_size_m1 <= sel_size;
            end
            core_rsp_valid <= rsp_hit;
            if (rsp_hit) core_rsp_id <= up_rsp_id;
            busy <= any_active;
        end
    end

    assert property (@(posedge clk) disable iff (reset) up_rsp_valid |-> rsp_hit);

endmodule

// File: tb/tb_vx_socket_gbar_agg.sv
// Directed bench for the socket barrier aggregator: socket 0 instance for most
// scenarios, a socket 1 instance for the partial-socket participant count.
module tb_vx_socket_gbar_agg;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  core_req_valid;
    logic [11:0] core_req_id;
    logic [31:0] core_req_size_m1;
    logic [3:0]  core_req_ready;
    logic        core_rsp_valid;
    logic [2:0]  core_rsp_id;
    logic        up_req_valid;
    logic [2:0]  up_req_id;
    logic [7:0]  up_req_size_m1;
    logic        up_req_ready;
    logic        up_rsp_valid;
    logic [2:0]  up_rsp_id;
    logic        busy;

    logic [3:0]  s1_req_valid;
    logic [11:0] s1_req_id;
    logic [31:0] s1_req_size_m1;
    logic [3:0]  s1_req_ready;
    logic        s1_rsp_valid;
    logic [2:0]  s1_rsp_id;
    logic        s1_up_valid;
    logic [2:0]  s1_up_id;
    logic [7:0]  s1_up_size_m1;
    logic        s1_busy;

    int checkCount = 0;
    int passCount  = 0;
    int hsCount    = 0;

    always #5 clk = ~clk;

    vx_socket_gbar_agg #(.SOCKET_ID(0), .NUM_CORES(4), .NUM_BARRIERS(8), .SIZE_W(8)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_id(core_req_id),
        .core_req_size_m1(core_req_size_m1), .core_req_ready(core_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_id(core_rsp_id),
        .up_req_valid(up_req_valid), .up_req_id(up_req_id),
        .up_req_size_m1(up_req_size_m1), .up_req_ready(up_req_ready),
        .up_rsp_valid(up_rsp_valid), .up_rsp_id(up_rsp_id), .busy(busy)
    );

    vx_socket_gbar_agg #(.SOCKET_ID(1), .NUM_CORES(4), .NUM_BARRIERS(8), .SIZE_W(8)) dut_s1 (
        .clk(clk), .reset(reset),
        .core_req_valid(s1_req_valid), .core_req_id(s1_req_id),
        .core_req_size_m1(s1_req_size_m1), .core_req_ready(s1_req_ready),
        .core_rsp_valid(s1_rsp_valid), .core_rsp_id(s1_rsp_id),
        .up_req_valid(s1_up_valid), .up_req_id(s1_up_id),
        .up_req_size_m1(s1_up_size_m1), .up_req_ready(1'b0),
        .up_rsp_valid(1'b0), .up_rsp_id(3'd0), .busy(s1_busy)
    );

    always @(posedge clk)
        if (!reset && up_req_valid && up_req_ready) hsCount++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input int core, input logic v, input logic [2:0] id, input logic [7:0] size);
        core_req_valid[core]           = v;
        core_req_id[core*3 +: 3]       = id;
        core_req_size_m1[core*8 +: 8]  = size;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // All four cores arrive together; expects round-robin from core 0 and one upstream request.
    task automatic acceptAll(input logic [2:0] id, input logic [7:0] size);
        for (int k = 0; k < 4; k++) applyStimulus(k, 1'b1, id, size);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("accept_order", 32'(core_req_ready), 32'(4'b0001 << k));
            if (k == 3) checkOutput("no_early_up_req", 32'(up_req_valid), 32'd0);
            nextCycle();
            applyStimulus(k, 1'b0, 3'd0, 8'd0);
        end
        #1;
        checkOutput("up_req_valid", 32'(up_req_valid), 32'd1);
        checkOutput("up_req_id", 32'(up_req_id), 32'(id));
        checkOutput("up_req_size", 32'(up_req_size_m1), 32'(size >> 2));
    endtask

    initial begin
        reset = 1'b1;
        core_req_valid = '0; core_req_id = '0; core_req_size_m1 = '0;
        up_req_ready = 1'b0; up_rsp_valid = 1'b0; up_rsp_id = '0;
        s1_req_valid = '0; s1_req_id = '0; s1_req_size_m1 = '0;

        nextCycle();
        core_req_valid = 4'hF;
        #1;
        checkOutput("reset_ready", 32'(core_req_ready), 32'd0);
        nextCycle();
        checkOutput("reset_outputs", {28'd0, up_req_valid, core_rsp_valid, busy, 1'b0}, 32'd0);
        core_req_valid = '0;
        reset = 1'b0;

        $display("[TB] scenario: four cores coalesce on id 2");
        acceptAll(3'd2, 8'd7);

        $display("[TB] scenario: upstream backpressure and release");
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            checkOutput("up_req_hold", {20'd0, up_req_valid, up_req_id, up_req_size_m1}, {20'd0, 1'b1, 3'd2, 8'd1});
        end
        up_req_ready = 1'b1;
        nextCycle();
        up_req_ready = 1'b0;
        checkOutput("up_req_drop", 32'(up_req_valid), 32'd0);
        checkOutput("single_upstream", 32'(hsCount), 32'd1);
        up_rsp_valid = 1'b1; up_rsp_id = 3'd2;
        #1;
        checkOutput("rsp_not_early", 32'(core_rsp_valid), 32'd0);
        nextCycle();
        up_rsp_valid = 1'b0;
        checkOutput("rsp_pulse", {core_rsp_valid, core_rsp_id}, {1'b1, 3'd2});
        nextCycle();
        checkOutput("rsp_one_cycle", 32'(core_rsp_valid), 32'd0);
        checkOutput("busy_clear", 32'(busy), 32'd0);

        $display("[TB] scenario: core re-arrival stalls until release");
        applyStimulus(1, 1'b1, 3'd3, 8'd1);
        #1;
        checkOutput("rearr_first", 32'(core_req_ready), 32'b0010);
        nextCycle();
        #1;
        checkOutput("rearr_stall_collect", 32'(core_req_ready), 32'd0);
        applyStimulus(0, 1'b1, 3'd3, 8'd1);
        #1;
        checkOutput("rearr_other_core", 32'(core_req_ready), 32'b0001);
        nextCycle();
        applyStimulus(0, 1'b0, 3'd0, 8'd0);
        #1;
        checkOutput("rearr_stall_send", 32'(core_req_ready), 32'd0);
        checkOutput("rearr_up_req", {up_req_valid, up_req_id, up_req_size_m1}, {1'b1, 3'd3, 8'd0});
        up_req_ready = 1'b1;
        nextCycle();
        up_req_ready = 1'b0;
        #1;
        checkOutput("rearr_stall_wait", 32'(core_req_ready), 32'd0);
        up_rsp_valid = 1'b1; up_rsp_id = 3'd3;
        #1;
        checkOutput("rearr_stall_rsp", 32'(core_req_ready), 32'd0);
        nextCycle();
        up_rsp_valid = 1'b0;
        #1;
        checkOutput("rearr_rsp", {core_rsp_valid, core_rsp_id}, {1'b1, 3'd3});
        checkOutput("rearr_new_round", 32'(core_req_ready), 32'b0010);
        nextCycle();
        applyStimulus(1, 1'b0, 3'd0, 8'd0);

        $display("[TB] scenario: reset mid-round");
        applyStimulus(0, 1'b1, 3'd5, 8'd7);
        applyStimulus(2, 1'b1, 3'd5, 8'd7);
        #1;
        checkOutput("mid_rr_from2", 32'(core_req_ready), 32'b0100);
        nextCycle();
        applyStimulus(2, 1'b0, 3'd0, 8'd0);
        #1;
        checkOutput("mid_rr_wrap", 32'(core_req_ready), 32'b0001);
        nextCycle();
        applyStimulus(0, 1'b0, 3'd0, 8'd0);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        nextCycle();
        checkOutput("mid_reset_outs", {up_req_valid, up_req_id, up_req_size_m1, core_rsp_valid, core_rsp_id, busy, core_req_ready}, 32'd0);
        reset = 1'b0;
        acceptAll(3'd5, 8'd7);
        checkOutput("no_stale_rsp", 32'(core_rsp_valid), 32'd0);
        up_req_ready = 1'b1;
        nextCycle();
        up_req_ready = 1'b0;
        up_rsp_valid = 1'b1; up_rsp_id = 3'd5;
        nextCycle();
        up_rsp_valid = 1'b0;
        checkOutput("restart_rsp", {core_rsp_valid, core_rsp_id}, {1'b1, 3'd5});

        $display("[TB] scenario: lowest pending ID sent first");
        applyStimulus(0, 1'b1, 3'd6, 8'd0);
        applyStimulus(1, 1'b1, 3'd4, 8'd0);
        applyStimulus(2, 1'b1, 3'd1, 8'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("prio_accept", 32'(core_req_ready), 32'(4'b0001 << k));
            nextCycle();
            applyStimulus(k, 1'b0, 3'd0, 8'd0);
        end
        checkOutput("prio_first_held", {up_req_valid, up_req_id}, {1'b1, 3'd6});
        up_req_ready = 1'b1;
        nextCycle();
        checkOutput("prio_low_id", {up_req_valid, up_req_id}, {1'b1, 3'd1});
        nextCycle();
        checkOutput("prio_next_id", {up_req_valid, up_req_id}, {1'b1, 3'd4});
        nextCycle();
        up_req_ready = 1'b0;
        checkOutput("prio_drained", 32'(up_req_valid), 32'd0);
        up_rsp_valid = 1'b1; up_rsp_id = 3'd4;
        nextCycle();
        up_rsp_id = 3'd1;
        checkOutput("rel_id4", {core_rsp_valid, core_rsp_id}, {1'b1, 3'd4});
        nextCycle();
        up_rsp_id = 3'd6;
        checkOutput("rel_id1", {core_rsp_valid, core_rsp_id}, {1'b1, 3'd1});
        nextCycle();
        up_rsp_valid = 1'b0;
        checkOutput("rel_id6", {core_rsp_valid, core_rsp_id}, {1'b1, 3'd6});
        nextCycle();
        checkOutput("rel_done", {30'd0, core_rsp_valid, busy}, 32'd0);

        $display("[TB] scenario: socket 1 partial participation");
        s1_req_valid = 4'b0011;
        s1_req_id = '0;
        s1_req_size_m1 = {8'd5, 8'd5, 8'd5, 8'd5};
        #1;
        checkOutput("s1_accept0", 32'(s1_req_ready), 32'b0001);
        nextCycle();
        s1_req_valid[0] = 1'b0;
        #1;
        checkOutput("s1_accept1", 32'(s1_req_ready), 32'b0010);
        checkOutput("s1_not_yet", 32'(s1_up_valid), 32'd0);
        nextCycle();
        s1_req_valid[1] = 1'b0;
        checkOutput("s1_up_req", {s1_up_valid, s1_up_id, s1_up_size_m1}, {1'b1, 3'd0, 8'd1});

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
